// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer and its PC register, instruction memory and decode/execute side.
interface fetch_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic             pc_load;
    logic [WIDTH-1:0] pc_next;
    logic             imem_read;
    logic [WIDTH-1:0] imem_address;
    logic             imem_resp;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             ex_done;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             addr_misaligned;
    logic [31:0]      retire_count;

    // Sequencer side: owns the PC load strobe, the fetch request and the decode handoff.
    modport master (
        input  pc, imem_resp, imem_rdata, instr_ready, ex_done, redirect_valid, redirect_target,
        output pc_load, pc_next, imem_read, imem_address, instr, instr_valid, addr_misaligned,
               retire_count
    );

    modport slave (
        output pc, imem_resp, imem_rdata, instr_ready, ex_done, redirect_valid, redirect_target,
        input  pc_load, pc_next, imem_read, imem_address, instr, instr_valid, addr_misaligned,
               retire_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/issue/execute sequencer that drives the PC load strobe and instruction fetches.
// Optional macro ALIGN_CHECK_EN: misaligned redirect targets trap to TRAP_VEC without retiring.
module fetch_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0060)
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;

    state_t           state;
    logic             imem_read_q;
    logic             instr_valid_q;
    logic [WIDTH-1:0] instr_q;
    logic [31:0]      retire_q;
    logic             take;
    logic             misaligned;
    logic [WIDTH-1:0] pc_next_c;

    // The completing EXEC cycle is the only cycle in which the PC register is loaded.
    assign take = (state == EXEC) && bus.ex_done;

`ifdef ALIGN_CHECK_EN
    assign misaligned = take && bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        // NOTE: assign a default before any branch so every path drives pc_next_c and no latch is inferred.
        pc_next_c = '0;
        if (misaligned)
            pc_next_c = TRAP_VEC;
        else if (take)
            pc_next_c = bus.redirect_valid ? bus.redirect_target : bus.pc + WIDTH'(4);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            retire_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    imem_read_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_resp) begin
                        instr_q       <= bus.imem_rdata;
                        imem_read_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.ex_done) begin
                        if (!misaligned)
                            retire_q <= retire_q + 32'd1;
                        imem_read_q <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state         <= IDLE;
                    imem_read_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_load         = take;
    assign bus.pc_next         = pc_next_c;
    assign bus.imem_read       = imem_read_q;
    assign bus.imem_address    = imem_read_q ? bus.pc : '0;
    assign bus.instr           = instr_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.addr_misaligned = misaligned;
    assign bus.retire_count    = retire_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected fetches, instructions and PC loads;
// a negedge monitor pops and compares them whenever the DUT presents the matching output.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.WIDTH(32)) bus ();

    fetch_sequencer #(.WIDTH(32), .TRAP_VEC(32'h0000_0060)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] next;
        logic [31:0] mis;
        logic [31:0] retire;
    } load_t;

    logic [31:0] fetch_q[$];
    logic [31:0] instr_q[$];
    load_t       load_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plant model of the external PC register with its own reset vector.
    always @(posedge clk) begin
        if (rst)
            bus.pc <= 32'h0000_0060;
        else if (bus.pc_load)
            bus.pc <= bus.pc_next;
    end

    // Monitor: compares DUT outputs against the queued expectations on the falling edge.
    logic        prev_read, prev_valid, chk_retire;
    logic [31:0] cur_addr, cur_instr, exp_retire;
    load_t       ld;

    always @(negedge clk) begin
        if (rst) begin
            prev_read  = 1'b0;
            prev_valid = 1'b0;
            chk_retire = 1'b0;
        end else begin
            if (chk_retire) begin
                check("retire_count", bus.retire_count, exp_retire);
                check("misaligned_one_cycle", 32'(bus.addr_misaligned), 32'd0);
                chk_retire = 1'b0;
            end
            if (bus.imem_read && !prev_read) begin
                if (fetch_q.size() == 0) check("spurious_fetch", 32'(fetch_q.size()), 32'd1);
                else cur_addr = fetch_q.pop_front();
            end
            if (bus.imem_read) check("imem_address", bus.imem_address, cur_addr);
            if (bus.instr_valid && !prev_valid) begin
                if (instr_q.size() == 0) check("spurious_instr", 32'(instr_q.size()), 32'd1);
                else cur_instr = instr_q.pop_front();
            end
            if (bus.instr_valid) check("instr", bus.instr, cur_instr);
            if (bus.pc_load) begin
                if (load_q.size() == 0) begin
                    check("spurious_pc_load", 32'(load_q.size()), 32'd1);
                end else begin
                    ld = load_q.pop_front();
                    check("pc_next", bus.pc_next, ld.next);
                    check("addr_misaligned", 32'(bus.addr_misaligned), ld.mis);
                    exp_retire = ld.retire;
                    chk_retire = 1'b1;
                end
            end else begin
                check("idle_pc_next", bus.pc_next, 32'd0);
            end
            prev_read  = bus.imem_read;
            prev_valid = bus.instr_valid;
        end
    end

    // sel 0 waits for imem_read, sel 1 for instr_valid; bounded so a stuck DUT still reaches the summary.
    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (!(sel == 0 ? bus.imem_read : bus.instr_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(sel == 0 ? bus.imem_read : bus.instr_valid), 32'd1);
    endtask

    // Noise toggles ex_done/instr_ready during the wait cycles, which FETCH must ignore.
    task automatic do_fetch(input logic [31:0] addr, input int waits, input logic [31:0] data,
                            input bit noise);
        fetch_q.push_back(addr);
        instr_q.push_back(data);
        wait_for(0, "fetch_start");
        repeat (waits) begin
            bus.imem_rdata  = 32'hbad0_bad0;
            bus.ex_done     = noise;
            bus.instr_ready = noise;
            @(posedge clk); #1;
        end
        bus.ex_done     = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_resp   = 1'b1;
        bus.imem_rdata  = data;
        @(posedge clk); #1;
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = 32'hbad1_bad1;
    endtask

    task automatic do_issue(input int stall);
        wait_for(1, "issue_start");
        for (int i = 0; i < stall; i++) begin
            bus.ex_done         = i[0];
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = 32'h0000_0200;
            @(negedge clk);
            check("pc_load_in_issue", 32'(bus.pc_load), 32'd0);
            check("instr_valid_held", 32'(bus.instr_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus.ex_done        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
    endtask

    task automatic do_exec(input int waits, input logic redir, input logic [31:0] target,
                           input logic [31:0] exp_next, input logic [31:0] exp_mis,
                           input logic [31:0] exp_ret);
        load_q.push_back('{next: exp_next, mis: exp_mis, retire: exp_ret});
        repeat (waits) begin @(posedge clk); #1; end
        bus.ex_done         = 1'b1;
        bus.redirect_valid  = redir;
        bus.redirect_target = target;
        @(posedge clk); #1;
        bus.ex_done         = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
    endtask

    logic [31:0] mis_next, mis_flag, mis_ret;

    initial begin
        bus.imem_resp       = 1'b0;
        bus.imem_rdata      = 32'd0;
        bus.instr_ready     = 1'b0;
        bus.ex_done         = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_imem_read", 32'(bus.imem_read), 32'd0);
        check("reset_instr", bus.instr, 32'd0);
        check("reset_retire", bus.retire_count, 32'd0);
        check("reset_pc_load", 32'(bus.pc_load), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_imem_read", 32'(bus.imem_read), 32'd0);
        check("idle_imem_address", bus.imem_address, 32'd0);
        check("idle_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("idle_pc_load", 32'(bus.pc_load), 32'd0);
        @(posedge clk); #1;

        // Sequential instruction: 2 wait states, falls through to pc+4.
        do_fetch(32'h0000_0060, 2, 32'h0000_0013, 1'b0);
        do_issue(0);
        do_exec(0, 1'b0, 32'd0, 32'h0000_0064, 32'd0, 32'd1);

        // Decode stall with ex_done noise, then a taken redirect.
        do_fetch(32'h0000_0064, 0, 32'h0040_0093, 1'b0);
        do_issue(5);
        do_exec(2, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'd0, 32'd2);

        // Misaligned redirect target.
`ifdef ALIGN_CHECK_EN
        mis_next = 32'h0000_0060; mis_flag = 32'd1; mis_ret = 32'd2;
`else
        mis_next = 32'h0000_0102; mis_flag = 32'd0; mis_ret = 32'd3;
`endif
        do_fetch(32'h0000_0100, 1, 32'hdead_beef, 1'b1);
        do_issue(0);
        do_exec(1, 1'b1, 32'h0000_0102, mis_next, mis_flag, mis_ret);

        // Reset in the middle of a fetch; a late response in the IDLE cycle must be dropped.
        fetch_q.push_back(mis_next);
        wait_for(0, "abandoned_fetch_start");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_instr", bus.instr, 32'd0);
        check("midreset_retire", bus.retire_count, 32'd0);
        check("midreset_imem_read", 32'(bus.imem_read), 32'd0);
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("late_resp_idle_read", 32'(bus.imem_read), 32'd0);
        @(posedge clk); #1;
        bus.imem_resp = 1'b0;
        check("late_resp_ignored_instr", bus.instr, 32'd0);
        check("late_resp_no_valid", 32'(bus.instr_valid), 32'd0);

        // Post-reset stream, including pc+4 wrap at the top of the address space.
        do_fetch(32'h0000_0060, 1, 32'h0000_0013, 1'b0);
        do_issue(1);
        do_exec(0, 1'b1, 32'hffff_fffc, 32'hffff_fffc, 32'd0, 32'd1);
        do_fetch(32'hffff_fffc, 0, 32'h0000_006f, 1'b0);
        do_issue(0);
        do_exec(0, 1'b0, 32'd0, 32'h0000_0000, 32'd0, 32'd2);
        do_fetch(32'h0000_0000, 0, 32'h0080_0113, 1'b0);
        do_issue(0);
        fetch_q.push_back(32'h0000_0004);
        do_exec(3, 1'b0, 32'd0, 32'h0000_0004, 32'd0, 32'd3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
        check("instr_queue_drained", 32'(instr_q.size()), 32'd0);
        check("load_queue_drained", 32'(load_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
